// File: rtl/gumnut_pkg.sv
// Shared Gumnut constants and the PC-operation encoding used by control,
// newPC_unit and the return stack.
package gumnut_pkg;

    localparam int ADDR_W      = 12;
    localparam int STACK_DEPTH = 8;

    typedef enum logic [3:0] {
        PC_INC,
        PC_BZ,
        PC_BNZ,
        PC_BC,
        PC_BNC,
        PC_JMP,
        PC_ISR,
        PC_RST
    } pc_oper_e;

endpackage

// File: rtl/pc_stack_unit_if.sv
// Control-side bundle for the return stack and interrupt shadow.
interface pc_stack_unit_if #(
    parameter int ADDR_W = gumnut_pkg::ADDR_W,
    parameter int CNT_W  = $clog2(gumnut_pkg::STACK_DEPTH + 1)
);

    logic              push_i;
    logic              pop_i;
    logic [ADDR_W-1:0] push_addr_i;
    logic              clr_err_i;
    logic              int_save_i;
    logic              int_restore_i;
    logic [ADDR_W-1:0] int_pc_i;
    logic              zero_i;
    logic              carry_i;

    logic [ADDR_W-1:0] stack_addr_o;
    logic [ADDR_W-1:0] int_pc_o;
    logic              zero_o;
    logic              carry_o;
    logic              int_active_o;
    logic [CNT_W-1:0]  depth_o;
    logic              empty_o;
    logic              full_o;
    logic              overflow_o;
    logic              underflow_o;

    modport master (
        output push_i, pop_i, push_addr_i, clr_err_i,
               int_save_i, int_restore_i, int_pc_i, zero_i, carry_i,
        input  stack_addr_o, int_pc_o, zero_o, carry_o, int_active_o,
               depth_o, empty_o, full_o, overflow_o, underflow_o
    );

    modport slave (
        input  push_i, pop_i, push_addr_i, clr_err_i,
               int_save_i, int_restore_i, int_pc_i, zero_i, carry_i,
        output stack_addr_o, int_pc_o, zero_o, carry_o, int_active_o,
               depth_o, empty_o, full_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/int_shadow_regs.sv
// Single-level interrupt context: return PC plus Z/C, with a live bit.
// A second save while live is dropped; restore wins over a concurrent save.
module int_shadow_regs
    import gumnut_pkg::*;
#(
    parameter int PC_W = gumnut_pkg::ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            save,
    input  logic            restore,
    input  logic [PC_W-1:0] pc,
    input  logic            zero,
    input  logic            carry,
    output logic [PC_W-1:0] saved_pc,
    output logic            saved_zero,
    output logic            saved_carry,
    output logic            active
);

    // Saved values stay put on restore so control can reload them that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saved_pc    <= '0;
            saved_zero  <= 1'b0;
            saved_carry <= 1'b0;
            active      <= 1'b0;
        end else if (restore) begin
            if (active) active <= 1'b0;
        end else if (save && !active) begin
            saved_pc    <= pc;
            saved_zero  <= zero;
            saved_carry <= carry;
            active      <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Return-address stack feeding newPC_unit, plus the interrupt context shadow.
// Top of stack is read combinationally so ret can use it before the pop edge.
module pc_stack_unit #(
    parameter int ADDR_W = gumnut_pkg::ADDR_W,
    parameter int DEPTH  = gumnut_pkg::STACK_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    pc_stack_unit_if.slave bus
);

    import gumnut_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  sp, sp_nxt;
    logic [IDX_W-1:0]  top_idx, wr_idx;
    logic              empty, full, wr_en;
    logic              ev_of, ev_uf;
    logic              overflow, underflow;
    logic              push, pop;

    assign push    = bus.push_i;
    assign pop     = bus.pop_i;
    assign empty   = (sp == '0);
    assign full    = (sp == CNT_W'(DEPTH));
    assign top_idx = IDX_W'(sp - 1'b1);

    // Push+pop on a live stack overwrites the top; on empty it acts as a push.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = IDX_W'(sp);
        sp_nxt = sp;
        ev_of  = 1'b0;
        ev_uf  = 1'b0;
        if (push && pop) begin
            wr_en = 1'b1;
            if (empty) begin
                sp_nxt = sp + 1'b1;
                ev_uf  = 1'b1;
            end else begin
                wr_idx = top_idx;
            end
        end else if (push) begin
            if (full) begin
                ev_of = 1'b1;
            end else begin
                wr_en  = 1'b1;
                sp_nxt = sp + 1'b1;
            end
        end else if (pop) begin
            if (empty) ev_uf  = 1'b1;
            else       sp_nxt = sp - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_idx] <= bus.push_addr_i;
    end

    // Sticky flags: a fresh error in the clearing cycle still lands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            overflow  <= (overflow  & ~bus.clr_err_i) | ev_of;
            underflow <= (underflow & ~bus.clr_err_i) | ev_uf;
        end
    end

    assign bus.stack_addr_o = empty ? '0 : mem[top_idx];
    assign bus.depth_o      = sp;
    assign bus.empty_o      = empty;
    assign bus.full_o       = full;
    assign bus.overflow_o   = overflow;
    assign bus.underflow_o  = underflow;

    int_shadow_regs #(
        .PC_W (ADDR_W)
    ) u_shadow (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .save        (bus.int_save_i),
        .restore     (bus.int_restore_i),
        .pc          (bus.int_pc_i),
        .zero        (bus.zero_i),
        .carry       (bus.carry_i),
        .saved_pc    (bus.int_pc_o),
        .saved_zero  (bus.zero_o),
        .saved_carry (bus.carry_o),
        .active      (bus.int_active_o)
    );

endmodule
